// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic             bflop, amsb, bmsb;
  logic [CW-1:0]    cnt;
  logic             ai, bi, d, bout, last, accept;

  // Full-subtractor cell on the current LSBs, plus last-bit and accept decode
  always_comb begin
    ai     = sa[0];
    bi     = sb[0];
    d      = ai ^ bi ^ bflop;
    bout   = (~ai & bi) | (~(ai ^ bi) & bflop);
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && (state != RUN);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs decoded from state
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, borrow chain, bit counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bflop      <= 1'b0;
      amsb       <= 1'b0;
      bmsb       <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      res   <= '0;
      bflop <= borrow_in;
      amsb  <= a[WIDTH-1];
      bmsb  <= b[WIDTH-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      res   <= {d, res[WIDTH-1:1]};
      bflop <= bout;
      if (last) begin
        diff       <= {d, res[WIDTH-1:1]};
        borrow_out <= bout;
        overflow   <= (amsb ^ bmsb) & (d ^ amsb);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8): directed vectors with hand-computed results.
module tb_serial_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy, done, borrow_out, overflow;
  logic [W-1:0] diff;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_len = 0;
  int   last_done = -1;
  bit   b2b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_len = 0;
    end else begin
      if (busy) busy_len++;
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("borrow_out", 32'(borrow_out), 32'(e.bo));
          chk("overflow", 32'(overflow), 32'(e.ov));
          chk("busy_in_done", 32'(busy), 32'd0);
          chk("busy_len", busy_len, W);
          if (b2b && last_done >= 0) chk("done_interval", cyc - last_done, W + 1);
        end
        busy_len  = 0;
        last_done = cyc;
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic ebo, input logic eov);
    @(negedge clk);
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    q.push_back('{d: ed, bo: ebo, ov: eov});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d results pending expected 0", q.size());
      q.delete();
    end
  endtask

  logic [W-1:0] pa[4] = '{8'h7F, 8'h03, 8'h01, 8'h64};
  logic [W-1:0] pb[4] = '{8'h80, 8'h01, 8'h02, 8'h9C};
  logic         pc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] pd[4] = '{8'hFF, 8'h01, 8'hFF, 8'hC8};
  logic         pbo[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic         pov[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bo", 32'(borrow_out), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0); drain();
    issue(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0); drain();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); drain();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0); drain();
    issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0); drain();

    // start pulsed again mid-run with new operands: must be ignored
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // start held high: back-to-back operations every W+1 cycles
    last_done = -1;
    b2b = 1'b1;
    @(negedge clk);
    a = pa[0]; b = pb[0]; borrow_in = pc[0]; start = 1'b1;
    q.push_back('{d: pd[0], bo: pbo[0], ov: pov[0]});
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = 0;
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!done) begin
        total++;
        bad++;
        $display("FAIL b2b_wait: got done=0 expected done=1 (op %0d)", i);
      end
      if (i < 4) begin
        a = pa[i]; b = pb[i]; borrow_in = pc[i];
        q.push_back('{d: pd[i], bo: pbo[i], ov: pov[i]});
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    drain();
    b2b = 1'b0;
    repeat (3) @(negedge clk);

    // reset during RUN aborts with no done pulse
    @(negedge clk);
    a = 8'h12; b = 8'h34; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bo", 32'(borrow_out), 32'd0);
    chk("abort_ov", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    issue(8'h90, 8'h20, 1'b0, 8'h70, 1'b0, 1'b1); drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial two's-complement/unsigned subtractor: computes diff = a - b - borrow_in over WIDTH clock cycles, LSB first.
- Uses one full-subtractor cell plus a borrow flip-flop.
- Companion to the gate-level full-adder datapath; used where area matters more than latency.
- Parallel operand load, parallel result, start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend, sampled with accepted start
- b  input  WIDTH  subtrahend, sampled with accepted start
- borrow_in  input  1  initial borrow, sampled with accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- diff  output  WIDTH  result a - b - borrow_in (mod 2^WIDTH)
- borrow_out  output  1  final borrow; for unsigned operands, 1 iff a < b + borrow_in
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (async, rst_n=0) forces state IDLE and clears all outputs and internal registers:
  - busy=0, done=0, diff=0, borrow_out=0, overflow=0.
  - Shift registers, borrow flop and bit counter cleared.
- Release of reset is synchronous to clk.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0. On an edge with start=1:
    - load a and b into shift registers, borrow flop <= borrow_in, counter <= 0;
    - go to RUN, busy=1.
  - RUN: each edge processes the current LSBs ai and bi with the borrow flop value bin:
    - d = ai ^ bi ^ bin
    - bout = (~ai & bi) | (~(ai ^ bi) & bin)
    - d is shifted into the MSB of the result register; operand registers shift right; borrow flop <= bout; counter increments.
    - On the edge processing bit WIDTH-1:
      - go to DONE;
      - load diff from the completed result register;
      - borrow_out <= final bout;
      - overflow <= computed from the latched a and b MSBs and the final d;
      - done <= 1, busy <= 0.
  - DONE: lasts exactly one cycle with done=1, busy=0. Next edge:
    - done <= 0;
    - if start=1, accept a new operation exactly as in IDLE (back-to-back allowed);
    - otherwise go to IDLE.
- Latency: done is high in the cycle following the WIDTH-th clock edge after the edge that accepted start.
- Throughput: one operation per WIDTH+1 cycles with start held high.
- diff, borrow_out and overflow hold their values until the next done pulse; they never change while busy=1.
- start while busy=1 is ignored (no queuing); a, b and borrow_in may change freely after acceptance.
- Counter width is ceil(log2(WIDTH)) bits.
- On the last bit, the counter compare (count == WIDTH-1) takes priority over the increment; there is no wrap into an extra cycle.
- Reset asserted mid-RUN aborts the operation immediately:
  - outputs return to reset values;
  - no done pulse is produced;
  - the first start after release is processed normally.
- done and busy are never high simultaneously.

Test Plan:
- Reset then WIDTH=8, a=0x5A, b=0x3C, borrow_in=0, start 1 cycle -> busy high for 8 cycles, then done pulse; diff=0x1E, borrow_out=0, overflow=0.
- a=0x10, b=0x20, borrow_in=0 -> diff=0xF0, borrow_out=1, overflow=0; a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0; a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
- start held high continuously with alternating operand pairs -> done every 9 cycles, each result correct, busy never high in a done cycle.
- Pulse start again and change a/b at cycle 3 of RUN -> second start ignored, result reflects the originally latched operands.
- Assert rst_n=0 at cycle 4 of RUN -> busy, done, diff and flags go to 0 asynchronously, no done pulse; a new start after release gives a correct result.
